moore_detect_count: RTL and testbench

MOORE_DETECT_COUNT -- requirements
Module: moore_detect_count

---
 rtl/moore_detect_count.sv | 119 +++++++++++
 tb/tb_moore_detect_count.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/moore_detect_count.sv
// ---------------------------------------------------------------------------
// moore_detect_count
//
// This block is a Moore FSM that detects the serial pattern 1011, MSB first,
// with overlap. A prescaler in front of it selects which din_en strobes are
// actually sampled. A 4-bit counter records how many times the pattern has
// been detected.
//
// Parameters
//   SAMPLE_DIV  Number of din_en strobes per FSM sample, range 1..256.
//
// Ports
//   clk        in   Sole clock, rising edge.
//   rst_n      in   Synchronous, active-low reset.
//   din        in   Serial data bit. It is used only on a sample event.
//   din_en     in   din valid strobe. It may be a pulse or held high.
//   clr        in   Synchronous clear of the detection count only.
//   z          out  High while the FSM is in S4 (1011 seen).
//   state_hex  out  State code 0..4, for a 7-segment hex decoder.
//   count_hex  out  Detection count, for a 7-segment hex decoder.
//
// Configuration macro
//   MOORE_COUNT_SAT_EN  When this macro is defined, count_hex saturates at 15.
//                       When it is undefined, count_hex wraps from 15 to 0.
// ---------------------------------------------------------------------------
module moore_detect_count #(
    parameter int SAMPLE_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_en,
    input  logic       clr,
    output logic       z,
    output logic [3:0] state_hex,
    output logic [3:0] count_hex
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic          sample;
    logic          detect;

    function automatic logic [3:0] count_inc(input logic [3:0] c);
`ifdef MOORE_COUNT_SAT_EN
        count_inc = (c == 4'hF) ? c : c + 4'd1;
`else
        count_inc = c + 4'd1;
`endif
    endfunction

    // The prescaler advances only on din_en. The strobe that finds it at
    // its last value is the sample event.
    assign sample = din_en && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (din_en) begin
            if (sample) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S0: if (sample) state_nxt = din ? S1 : S0;
            S1: if (sample) state_nxt = din ? S1 : S2;
            S2: if (sample) state_nxt = din ? S3 : S0;
            S3: if (sample) state_nxt = din ? S4 : S2;
            S4: if (sample) state_nxt = din ? S1 : S2;
            // An encoding outside S0..S4 is forced back to idle on the next
            // edge, whether or not a sample event occurs.
            default: state_nxt = S0;
        endcase
    end

    // S4 can only be entered from S3, and S4 always leaves on a sample.
    // Because of that, this condition is true exactly once per detection.
    assign detect = sample && (state == S3) && din;

    // state_hex and z are registered from state_nxt and are not decoded
    // from state. This means that an illegal state register value never
    // reaches the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S0;
            state_hex <= 4'd0;
            z         <= 1'b0;
            count_hex <= 4'd0;
        end else begin
            state     <= state_nxt;
            state_hex <= {1'b0, state_nxt};
            z         <= (state_nxt == S4);
            if (clr) begin
                count_hex <= 4'd0;
            end else if (detect) begin
                count_hex <= count_inc(count_hex);
            end
        end
    end

endmodule

// File: tb/tb_moore_detect_count.sv
module tb_moore_detect_count;

    logic       clk = 1'b0;
    logic       rst_n1, din1, en1, clr1;
    logic       z1;
    logic [3:0] st1, cnt1;
    logic       rst_n2, din2, en2, clr2;
    logic       z2;
    logic [3:0] st2, cnt2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    moore_detect_count #(.SAMPLE_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .din(din1), .din_en(en1), .clr(clr1),
        .z(z1), .state_hex(st1), .count_hex(cnt1)
    );

    moore_detect_count #(.SAMPLE_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n2), .din(din2), .din_en(en2), .clr(clr2),
        .z(z2), .state_hex(st2), .count_hex(cnt2)
    );

    typedef struct {
        logic       rst_n;
        logic       din;
        logic       en;
        logic       clr;
        logic [3:0] st;
        logic       z;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step1(input logic r, input logic d, input logic e, input logic c);
        rst_n1 = r; din1 = d; en1 = e; clr1 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic r, input logic d, input logic e, input logic c);
        rst_n2 = r; din2 = d; en2 = e; clr2 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic [3:0] st, input logic zz, input logic [3:0] cnt);
        check({tag, ".state"}, {4'd0, st1}, {4'd0, st});
        check({tag, ".z"}, {7'd0, z1}, {7'd0, zz});
        check({tag, ".count"}, {4'd0, cnt1}, {4'd0, cnt});
    endtask

    initial begin
        logic [3:0] wrap_exp;
        logic       bits[4];

        rst_n1 = 1'b0; din1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
        rst_n2 = 1'b0; din2 = 1'b0; en2 = 1'b0; clr2 = 1'b0;

        //             rst  din en  clr  st  z  cnt
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 4'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 4'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 4'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 4'd2};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 4'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd2};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 4'd1};

        // Reset held for two cycles with random data and strobe.
        for (int i = 0; i < 2; i++) begin
            step1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check1("reset", 4'd0, 1'b0, 4'd0);

        // Table-driven vectors on the SAMPLE_DIV=1 instance.
        for (int i = 0; i < 22; i++) begin
            step1(vecs[i].rst_n, vecs[i].din, vecs[i].en, vecs[i].clr);
            check1($sformatf("vec%0d", i), vecs[i].st, vecs[i].z, vecs[i].cnt);
        end

        // clr colliding with a detection. The count is 5 beforehand.
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b0, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step1(1'b1, 1'b0, 1'b1, 1'b0);
            step1(1'b1, 1'b1, 1'b1, 1'b0);
            step1(1'b1, 1'b1, 1'b1, 1'b0);
        end
        check1("clrcol.pre", 4'd4, 1'b1, 4'd5);
        step1(1'b1, 1'b0, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b1);
        check1("clrcol", 4'd4, 1'b1, 4'd0);

        // Wrap or saturate after 16 detections.
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b0, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step1(1'b1, 1'b0, 1'b1, 1'b0);
            step1(1'b1, 1'b1, 1'b1, 1'b0);
            step1(1'b1, 1'b1, 1'b1, 1'b0);
        end
        check1("wrap.15", 4'd4, 1'b1, 4'd15);
`ifdef MOORE_COUNT_SAT_EN
        wrap_exp = 4'd15;
`else
        wrap_exp = 4'd0;
`endif
        step1(1'b1, 1'b0, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        check1("wrap.16", 4'd4, 1'b1, wrap_exp);

        // Reset in the middle of a partial match.
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b0, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        check1("midrst.pre", 4'd3, 1'b0, 4'd0);
        step1(1'b0, 1'b1, 1'b1, 1'b0);
        check1("midrst.rst", 4'd0, 1'b0, 4'd0);
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        check1("midrst.post", 4'd1, 1'b0, 4'd0);

        // Prescaler with SAMPLE_DIV=3 and din_en held high. Only the third
        // cycle of each group is sampled, so the bit is inverted on the
        // first two cycles of the group.
        for (int i = 0; i < 2; i++) begin
            step2(1'b0, 1'($urandom), 1'($urandom), 1'b0);
        end
        check("presc.reset", {3'd0, z2, cnt2}, 8'd0);
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 3; c++) begin
                step2(1'b1, (c == 2) ? bits[b] : ~bits[b], 1'b1, 1'b0);
                check($sformatf("presc.b%0dc%0d.state", b, c), {4'd0, st2},
                      (c == 2) ? 8'(b + 1) : 8'(b));
            end
        end
        check("presc.z", {7'd0, z2}, 8'd1);
        check("presc.count", {4'd0, cnt2}, 8'd1);
        // din_en is dropped for one cycle. Both the prescaler and the state hold.
        step2(1'b1, 1'b1, 1'b0, 1'b0);
        check("presc.hold", {4'd0, st2}, 8'd4);
        step2(1'b1, 1'b1, 1'b1, 1'b0);
        step2(1'b1, 1'b1, 1'b1, 1'b0);
        check("presc.hold2", {4'd0, st2}, 8'd4);
        step2(1'b1, 1'b0, 1'b1, 1'b0);
        check("presc.next", {3'd0, z2, st2}, 8'd2);
        check("presc.count2", {4'd0, cnt2}, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
